// File: rtl/pe_array_seq_ctrl.sv
// pe_array_seq_ctrl: job sequencer for the 16-row bit-fusion PE array and its accumulator.
// Defining PE_CTRL_PERF_EN adds the o_Busy_Cycles / o_Stall_Cycles performance counters.
module pe_array_seq_ctrl #(
  parameter int AW       = 16,
  parameter int KW       = 8,
  parameter int NW       = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_Cmd_Vld,
  output logic          o_Cmd_Rdy,
  input  logic [3:0]    i_Cmd_Prec,
  input  logic [KW-1:0] i_Cmd_K,
  input  logic [NW-1:0] i_Cmd_N,
  input  logic [AW-1:0] i_Cmd_ActBase,
  input  logic          i_Stall,
  input  logic          i_Abort,
  output logic [3:0]    o_Precision,
  output logic          o_Sel_Bias,
  output logic          o_Flush,
  output logic          o_Core_Vld,
  output logic [AW-1:0] o_Act_Addr,
  output logic [KW-1:0] o_Wgt_Addr,
  output logic [NW-1:0] o_Bias_Addr,
  output logic          o_Res_Vld,
  output logic [NW-1:0] o_Res_Idx,
  output logic          o_Busy,
  output logic          o_Job_Done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]   o_Busy_Cycles,
  output logic [31:0]   o_Stall_Cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_r, state_nx_s;
  logic [KW-1:0]              k_r, chunk_r;
  logic [NW-1:0]              n_r, out_r;
  logic [AW-1:0]              act_next_r;
  logic                       last_r;
  logic [PIPE_LAT-1:0]        dly_vld_r;
  logic [PIPE_LAT-1:0][NW-1:0] dly_idx_r;
  logic [PIPE_LAT:0]          pipe_vld_s;
  logic [PIPE_LAT:0][NW-1:0]  pipe_idx_s;
  logic                       accept_s, issue_s, abort_s, pend_s;
  logic                       end_chunk_s, end_out_s, empty_job_s;

  assign o_Cmd_Rdy   = (state_r == S_IDLE);
  assign o_Busy      = (state_r != S_IDLE);
  assign end_chunk_s = (chunk_r == (k_r - KW'(1)));
  assign end_out_s   = (out_r == (n_r - NW'(1)));
  assign empty_job_s = (i_Cmd_K == {KW{1'b0}}) || (i_Cmd_N == {NW{1'b0}});

  // The registered beat stage is the head of the result delay line; the final
  // stage is excluded from pend_s so DONE lands the cycle after the last result.
  assign pipe_vld_s = {dly_vld_r, last_r};
  assign pipe_idx_s = {dly_idx_r, o_Bias_Addr};
  assign pend_s     = |pipe_vld_s[PIPE_LAT-1:0];
  assign o_Res_Vld  = dly_vld_r[PIPE_LAT-1];
  assign o_Res_Idx  = dly_idx_r[PIPE_LAT-1];

  // Next-state and issue decisions
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    issue_s    = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_Cmd_Vld) begin
          accept_s = 1'b1;
          if (empty_job_s) begin
            state_nx_s = S_DONE;
          end else begin
            state_nx_s = S_RUN;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_Abort) begin
          abort_s    = 1'b1;
          state_nx_s = S_IDLE;
        end else if (!i_Stall) begin
          issue_s = 1'b1;
          if (end_chunk_s && end_out_s) begin
            state_nx_s = S_DRAIN;
          end else begin
            state_nx_s = S_RUN;
          end
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (i_Abort) begin
          abort_s    = 1'b1;
          state_nx_s = S_IDLE;
        end else if (!pend_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      S_DONE: begin
        abort_s    = i_Abort;
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Job context and chunk/output counters; act address advances by one per beat
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_Precision <= 4'd0;
      k_r         <= {KW{1'b0}};
      n_r         <= {NW{1'b0}};
      chunk_r     <= {KW{1'b0}};
      out_r       <= {NW{1'b0}};
      act_next_r  <= {AW{1'b0}};
    end else if (accept_s) begin
      o_Precision <= i_Cmd_Prec;
      k_r         <= i_Cmd_K;
      n_r         <= i_Cmd_N;
      chunk_r     <= {KW{1'b0}};
      out_r       <= {NW{1'b0}};
      act_next_r  <= i_Cmd_ActBase;
    end else if (issue_s) begin
      act_next_r <= act_next_r + AW'(1);
      if (end_chunk_s) begin
        chunk_r <= {KW{1'b0}};
        out_r   <= out_r + NW'(1);
      end else begin
        chunk_r <= chunk_r + KW'(1);
      end
    end
  end

  // Beat outputs to the array and operand buffers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_Core_Vld  <= 1'b0;
      o_Sel_Bias  <= 1'b0;
      o_Act_Addr  <= {AW{1'b0}};
      o_Wgt_Addr  <= {KW{1'b0}};
      o_Bias_Addr <= {NW{1'b0}};
      last_r      <= 1'b0;
    end else if (issue_s) begin
      o_Core_Vld  <= 1'b1;
      o_Sel_Bias  <= (chunk_r == {KW{1'b0}});
      o_Act_Addr  <= act_next_r;
      o_Wgt_Addr  <= chunk_r;
      o_Bias_Addr <= out_r;
      last_r      <= end_chunk_s;
    end else begin
      o_Core_Vld  <= 1'b0;
      o_Sel_Bias  <= 1'b0;
      last_r      <= 1'b0;
    end
  end

  // Result delay line, flush and job-done pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_Flush    <= 1'b0;
      o_Job_Done <= 1'b0;
      dly_vld_r  <= {PIPE_LAT{1'b0}};
      dly_idx_r  <= {(PIPE_LAT*NW){1'b0}};
    end else begin
      o_Flush    <= abort_s;
      o_Job_Done <= (state_nx_s == S_DONE);
      if (abort_s) begin
        dly_vld_r <= {PIPE_LAT{1'b0}};
        dly_idx_r <= {(PIPE_LAT*NW){1'b0}};
      end else begin
        dly_vld_r <= pipe_vld_s[PIPE_LAT-1:0];
        dly_idx_r <= pipe_idx_s[PIPE_LAT-1:0];
      end
    end
  end

`ifdef PE_CTRL_PERF_EN
  // Saturating busy/stall counters, restarted on each accepted command
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_Busy_Cycles  <= 32'd0;
      o_Stall_Cycles <= 32'd0;
    end else if (accept_s) begin
      o_Busy_Cycles  <= 32'd0;
      o_Stall_Cycles <= 32'd0;
    end else begin
      if (o_Busy && (o_Busy_Cycles != 32'hFFFF_FFFF)) begin
        o_Busy_Cycles <= o_Busy_Cycles + 32'd1;
      end else begin
        o_Busy_Cycles <= o_Busy_Cycles;
      end
      if ((state_r == S_RUN) && i_Stall && (o_Stall_Cycles != 32'hFFFF_FFFF)) begin
        o_Stall_Cycles <= o_Stall_Cycles + 32'd1;
      end else begin
        o_Stall_Cycles <= o_Stall_Cycles;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Self-checking bench for pe_array_seq_ctrl: table-driven jobs with a beat/result
// scoreboard, plus hand-written abort and mid-job reset sequences.
`timescale 1ns/1ps
module tb_pe_array_seq_ctrl;
  localparam int AW = 16;
  localparam int KW = 8;
  localparam int NW = 10;
  localparam int PL = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          i_Cmd_Vld = 1'b0;
  logic          o_Cmd_Rdy;
  logic [3:0]    i_Cmd_Prec = 4'd0;
  logic [KW-1:0] i_Cmd_K = 8'd0;
  logic [NW-1:0] i_Cmd_N = 10'd0;
  logic [AW-1:0] i_Cmd_ActBase = 16'd0;
  logic          i_Stall = 1'b0;
  logic          i_Abort = 1'b0;
  logic [3:0]    o_Precision;
  logic          o_Sel_Bias, o_Flush, o_Core_Vld, o_Res_Vld, o_Busy, o_Job_Done;
  logic [AW-1:0] o_Act_Addr;
  logic [KW-1:0] o_Wgt_Addr;
  logic [NW-1:0] o_Bias_Addr, o_Res_Idx;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]   o_Busy_Cycles, o_Stall_Cycles;
`endif

  pe_array_seq_ctrl #(.AW(AW), .KW(KW), .NW(NW), .PIPE_LAT(PL)) dut (
    .CLK(CLK), .RST(RST), .i_Cmd_Vld(i_Cmd_Vld), .o_Cmd_Rdy(o_Cmd_Rdy),
    .i_Cmd_Prec(i_Cmd_Prec), .i_Cmd_K(i_Cmd_K), .i_Cmd_N(i_Cmd_N),
    .i_Cmd_ActBase(i_Cmd_ActBase), .i_Stall(i_Stall), .i_Abort(i_Abort),
    .o_Precision(o_Precision), .o_Sel_Bias(o_Sel_Bias), .o_Flush(o_Flush),
    .o_Core_Vld(o_Core_Vld), .o_Act_Addr(o_Act_Addr), .o_Wgt_Addr(o_Wgt_Addr),
    .o_Bias_Addr(o_Bias_Addr), .o_Res_Vld(o_Res_Vld), .o_Res_Idx(o_Res_Idx),
    .o_Busy(o_Busy), .o_Job_Done(o_Job_Done)
`ifdef PE_CTRL_PERF_EN
    , .o_Busy_Cycles(o_Busy_Cycles), .o_Stall_Cycles(o_Stall_Cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]    prec;
    logic [KW-1:0] k;
    logic [NW-1:0] n;
    logic [AW-1:0] base;
    int            stall_at;
    int            stall_len;
    bit            hold_cmd;
    int            exp_beats;
    int            exp_res;
    int            exp_gap;
  } job_t;

  typedef struct {
    logic          sel;
    logic [AW-1:0] act;
    logic [KW-1:0] wgt;
    logic [NW-1:0] bias;
    logic          last;
  } beat_t;

  job_t          jobs[7];
  beat_t         beat_q[$];
  logic [NW-1:0] res_q[$];
  int            due_q[$];
  int cyc = 0;
  int beats_seen = 0, res_seen = 0, done_pulses = 0;
  int last_res_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  int errors = 0, checks = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard fill: expected beats and result indices of a job
  task automatic push_job(input logic [KW-1:0] k, input logic [NW-1:0] n, input logic [AW-1:0] base);
    beat_t b;
    if (k != 8'd0 && n != 10'd0) begin
      for (int o = 0; o < int'(n); o++) begin
        for (int c = 0; c < int'(k); c++) begin
          b.sel  = (c == 0);
          b.act  = base + AW'(o * int'(k) + c);
          b.wgt  = c[KW-1:0];
          b.bias = o[NW-1:0];
          b.last = (c == int'(k) - 1);
          beat_q.push_back(b);
        end
        res_q.push_back(o[NW-1:0]);
      end
    end
  endtask

  // Output monitor: pops scoreboard on every beat and result
  always @(negedge CLK) begin
    if (RST) begin
      if (o_Core_Vld) begin
        beat_t e;
        if (beats_seen == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats_seen++;
        if (beat_q.size() == 0) begin
          fail_now("beat_unexpected");
        end else begin
          e = beat_q.pop_front();
          chk("sel_bias", 32'(o_Sel_Bias), 32'(e.sel));
          chk("act_addr", 32'(o_Act_Addr), 32'(e.act));
          chk("wgt_addr", 32'(o_Wgt_Addr), 32'(e.wgt));
          chk("bias_addr", 32'(o_Bias_Addr), 32'(e.bias));
          if (e.last) due_q.push_back(cyc + PL);
        end
      end else begin
        chk("sel_bias_idle", 32'(o_Sel_Bias), 32'd0);
      end
      if (o_Res_Vld) begin
        res_seen++;
        last_res_cyc = cyc;
        if (res_q.size() == 0 || due_q.size() == 0) begin
          fail_now("res_unexpected");
        end else begin
          chk("res_idx", 32'(o_Res_Idx), 32'(res_q.pop_front()));
          chk("res_time", 32'(cyc), 32'(due_q.pop_front()));
        end
      end
      if (o_Job_Done) done_pulses++;
    end
  end

  task automatic clear_sb();
    beat_q.delete();
    res_q.delete();
    due_q.delete();
    beats_seen = 0;
    res_seen = 0;
    done_pulses = 0;
  endtask

  task automatic run_job(input job_t j);
    int  budget;
    bit  done;
    clear_sb();
    @(negedge CLK);
    chk("rdy_idle", 32'(o_Cmd_Rdy), 32'd1);
    chk("busy_idle", 32'(o_Busy), 32'd0);
    i_Cmd_Vld = 1'b1; i_Cmd_Prec = j.prec; i_Cmd_K = j.k; i_Cmd_N = j.n; i_Cmd_ActBase = j.base;
    push_job(j.k, j.n, j.base);
    @(negedge CLK);
    chk("prec_latched", 32'(o_Precision), 32'(j.prec));
    if (j.hold_cmd) begin
      i_Cmd_Prec = ~j.prec; i_Cmd_K = 8'd1; i_Cmd_N = 10'd1;
    end else begin
      i_Cmd_Vld = 1'b0;
    end
    done = 1'b0;
    budget = 0;
    while (!done && budget < 200) begin
      if (o_Job_Done) begin
        done = 1'b1;
        i_Cmd_Vld = 1'b0;
        i_Stall = 1'b0;
        if (j.exp_res == 0) chk("done_empty_latency", 32'(budget), 32'd0);
        else                chk("done_timing", 32'(cyc), 32'(last_res_cyc + 1));
      end else begin
        if (j.hold_cmd) chk("prec_hold", 32'(o_Precision), 32'(j.prec));
        i_Stall = (budget >= j.stall_at) && (budget < j.stall_at + j.stall_len);
        budget++;
        @(negedge CLK);
      end
    end
    if (!done) fail_now("job_done_timeout");
    i_Stall = 1'b0;
    i_Cmd_Vld = 1'b0;
    @(negedge CLK);
    chk("rdy_after_job", 32'(o_Cmd_Rdy), 32'd1);
    chk("beat_count", 32'(beats_seen), 32'(j.exp_beats));
    chk("res_count", 32'(res_seen), 32'(j.exp_res));
    chk("done_pulses", 32'(done_pulses), 32'd1);
    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    if (j.exp_beats > 0)
      chk("stall_gap", 32'((last_beat_cyc - first_beat_cyc) - (beats_seen - 1)), 32'(j.exp_gap));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    //          prec     K      N       base      st len hold beats res gap
    jobs[0] = '{4'b1010, 8'd3, 10'd2, 16'h0100, 0, 0, 1'b1, 6, 2, 0};
    jobs[1] = '{4'b1010, 8'd3, 10'd2, 16'h0100, 1, 3, 1'b0, 6, 2, 3};
    jobs[2] = '{4'b0000, 8'd1, 10'd4, 16'h0020, 0, 0, 1'b0, 4, 4, 0};
    jobs[3] = '{4'b1001, 8'd4, 10'd1, 16'hFFFE, 0, 0, 1'b0, 4, 1, 0};
    jobs[4] = '{4'b0110, 8'd5, 10'd0, 16'h0300, 0, 0, 1'b0, 0, 0, 0};
    jobs[5] = '{4'b0101, 8'd0, 10'd3, 16'h0300, 0, 0, 1'b0, 0, 0, 0};
    jobs[6] = '{4'b1000, 8'd2, 10'd3, 16'h0007, 0, 2, 1'b0, 6, 3, 0};

    #2;
    chk("rst_cmd_rdy", 32'(o_Cmd_Rdy), 32'd1);
    chk("rst_core_vld", 32'(o_Core_Vld), 32'd0);
    chk("rst_precision", 32'(o_Precision), 32'd0);
    chk("rst_act_addr", 32'(o_Act_Addr), 32'd0);
    chk("rst_res_vld", 32'(o_Res_Vld), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) run_job(jobs[i]);

    // Abort on beat 6 of a K=4,N=3 job: only result 0 survives
    clear_sb();
    @(negedge CLK);
    i_Cmd_Vld = 1'b1; i_Cmd_Prec = 4'b0101; i_Cmd_K = 8'd4; i_Cmd_N = 10'd3; i_Cmd_ActBase = 16'h0040;
    push_job(8'd4, 10'd3, 16'h0040);
    @(negedge CLK);
    i_Cmd_Vld = 1'b0;
    for (int t = 0; t < 60 && beats_seen < 6; t++) begin
      @(negedge CLK);
      #1;
    end
    if (beats_seen != 6) fail_now("abort_wait_timeout");
    i_Abort = 1'b1;
    @(negedge CLK);
    i_Abort = 1'b0;
    chk("abort_flush", 32'(o_Flush), 32'd1);
    chk("abort_core_vld", 32'(o_Core_Vld), 32'd0);
    chk("abort_cmd_rdy", 32'(o_Cmd_Rdy), 32'd1);
    chk("abort_res_left", 32'(res_q.size()), 32'd2);
    beat_q.delete();
    res_q.delete();
    @(negedge CLK);
    chk("abort_flush_pulse", 32'(o_Flush), 32'd0);
    repeat (6) @(negedge CLK);
    chk("abort_res_count", 32'(res_seen), 32'd1);
    chk("abort_no_done", 32'(done_pulses), 32'd0);

    // Asynchronous reset in the middle of a job
    clear_sb();
    @(negedge CLK);
    i_Cmd_Vld = 1'b1; i_Cmd_Prec = 4'b1010; i_Cmd_K = 8'd5; i_Cmd_N = 10'd2; i_Cmd_ActBase = 16'h0200;
    push_job(8'd5, 10'd2, 16'h0200);
    @(negedge CLK);
    i_Cmd_Vld = 1'b0;
    for (int t = 0; t < 60 && beats_seen < 3; t++) begin
      @(negedge CLK);
      #1;
    end
    if (beats_seen != 3) fail_now("reset_wait_timeout");
    RST = 1'b0;
    #1;
    chk("mid_rst_core_vld", 32'(o_Core_Vld), 32'd0);
    chk("mid_rst_act", 32'(o_Act_Addr), 32'd0);
    chk("mid_rst_wgt", 32'(o_Wgt_Addr), 32'd0);
    chk("mid_rst_bias", 32'(o_Bias_Addr), 32'd0);
    chk("mid_rst_prec", 32'(o_Precision), 32'd0);
    chk("mid_rst_flush", 32'(o_Flush), 32'd0);
    chk("mid_rst_cmd_rdy", 32'(o_Cmd_Rdy), 32'd1);
    chk("mid_rst_busy", 32'(o_Busy), 32'd0);
    clear_sb();
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    chk("post_rst_beats", 32'(beats_seen), 32'd0);
    chk("post_rst_done", 32'(done_pulses), 32'd0);
    chk("post_rst_rdy", 32'(o_Cmd_Rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
